// File: rtl/sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sequencer_pkg
// Description : Shared constants and types for the sequencer pattern store
//               and its playback reader.
// Revision    : 1.0 - initial release
// ============================================================================
package sequencer_pkg;

    localparam int NUM_STEPS = 16;
    localparam int PITCH_W   = 3;
    localparam int INDEX_W   = 4;
    localparam int BEATS_W   = NUM_STEPS * PITCH_W;

    // Pitch code 0 marks a silent step.
    localparam logic [PITCH_W-1:0] PITCH_REST = 3'd0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } player_state_t;

endpackage
`default_nettype wire

// File: rtl/sequencer_player_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : step_timer
// Description : Tempo divider for the sequencer player. Counts clk cycles
//               within a step and flags the last cycle of each step. The
//               step period is latched at every step entry so tempo changes
//               only apply from the following step.
// Revision    : 1.0 - initial release
// ============================================================================
module step_timer #(
    parameter int TICK_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_restart,
    input  logic              i_run,
    input  logic [TICK_W-1:0] i_ticks_per_step,
    output logic              o_terminal,
    output logic [TICK_W-1:0] o_tick_cnt,
    output logic [TICK_W-1:0] o_period
);

    localparam logic [TICK_W-1:0] c_one = TICK_W'(1);

    logic [TICK_W-1:0] r_tick_cnt;
    logic [TICK_W-1:0] r_period_q;
    logic              w_step;

    // Terminal only while running, so IDLE and a stop cycle never strobe.
    assign o_terminal = i_run && (r_tick_cnt == (r_period_q - c_one));
    assign w_step     = i_restart || o_terminal;
    assign o_tick_cnt = r_tick_cnt;
    assign o_period   = r_period_q;

    // Count cycles within the step; a zero tempo is clamped to one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_period_q <= c_one;
        end else if (w_step) begin
            r_tick_cnt <= '0;
            r_period_q <= (i_ticks_per_step == '0) ? c_one : i_ticks_per_step;
        end else if (i_run) begin
            r_tick_cnt <= r_tick_cnt + c_one;
        end else begin
            r_tick_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sequencer_player.sv
`default_nettype none
// ============================================================================
// Module      : sequencer_player
// Description : Playback reader for the 16-step sequencer pattern. Walks the
//               beats vector at a programmable tempo and hands one note per
//               non-rest step to the tone generator over valid/ready.
//               Optional macro SEQUENCER_PLAYER_GATE_EN enables the note gate
//               output; otherwise o_gate is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module sequencer_player
    import sequencer_pkg::*;
#(
    parameter int TICK_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BEATS_W-1:0] i_beats,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [TICK_W-1:0]  i_ticks_per_step,
    output logic               o_playing,
    output logic [INDEX_W-1:0] o_beat_index,
    output logic               o_step_strobe,
    output logic               o_note_valid,
    output logic [PITCH_W-1:0] o_note_pitch,
    input  logic               i_note_ready,
    output logic               o_overrun,
    output logic               o_gate
);

    player_state_t      r_state;
    player_state_t      w_state_nxt;

    logic [INDEX_W-1:0] r_beat_index;
    logic               r_step_strobe;
    logic               r_note_valid;
    logic [PITCH_W-1:0] r_note_pitch;
    logic               r_overrun;

    logic               w_take_start;
    logic               w_stop_play;
    logic               w_run;
    logic               w_terminal;
    logic               w_step_entry;
    logic [INDEX_W-1:0] w_next_index;
    logic [PITCH_W-1:0] w_pitch;
    logic               w_note_load;
    logic [TICK_W-1:0]  w_tick_cnt;
    logic [TICK_W-1:0]  w_period;

    // Stop always wins over a simultaneous start.
    assign w_take_start = i_start && !i_stop;
    assign w_stop_play  = (r_state == PLAY) && i_stop;
    assign w_run        = (r_state == PLAY) && !i_stop;
    assign w_step_entry = w_take_start || w_terminal;
    assign w_next_index = w_take_start ? '0 : (r_beat_index + INDEX_W'(1));
    assign w_pitch      = i_beats[w_next_index*PITCH_W +: PITCH_W];
    assign w_note_load  = w_step_entry && (w_pitch != PITCH_REST);

    step_timer #(
        .TICK_W (TICK_W)
    ) u_step_timer (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_restart        (w_take_start),
        .i_run            (w_run),
        .i_ticks_per_step (i_ticks_per_step),
        .o_terminal       (w_terminal),
        .o_tick_cnt       (w_tick_cnt),
        .o_period         (w_period)
    );

    // Playback state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: start enters (or restarts) play, stop returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_take_start) w_state_nxt = PLAY;
            PLAY:    if (i_stop)       w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Step index, strobe and note handshake; a new note always replaces the
    // pending one, and a transfer on the same edge as a load is not an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_index  <= '0;
            r_step_strobe <= 1'b0;
            r_note_valid  <= 1'b0;
            r_note_pitch  <= '0;
            r_overrun     <= 1'b0;
        end else if (w_stop_play) begin
            r_beat_index  <= '0;
            r_step_strobe <= 1'b0;
            r_note_valid  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_step_strobe <= w_step_entry;
            r_overrun     <= w_note_load && r_note_valid && !i_note_ready;
            if (w_step_entry) begin
                r_beat_index <= w_next_index;
            end
            if (w_note_load) begin
                r_note_valid <= 1'b1;
                r_note_pitch <= w_pitch;
            end else if (r_note_valid && i_note_ready && (r_state == PLAY)) begin
                r_note_valid <= 1'b0;
            end
        end
    end

`ifdef SEQUENCER_PLAYER_GATE_EN
    logic r_note_step;

    // Remember whether the current step sounds a note; cleared outside play.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_note_step <= 1'b0;
        end else if (w_stop_play) begin
            r_note_step <= 1'b0;
        end else if (w_step_entry) begin
            r_note_step <= (w_pitch != PITCH_REST);
        end
    end

    // Gate drops for the final quarter of the step; short steps stay high.
    assign o_gate = (r_state == PLAY) && r_note_step &&
                    (w_tick_cnt < (w_period - (w_period >> 2)));
`else
    logic w_unused_gate;
    assign w_unused_gate = ^{w_tick_cnt, w_period};
    assign o_gate        = 1'b0;
`endif

    assign o_playing     = (r_state == PLAY);
    assign o_beat_index  = r_beat_index;
    assign o_step_strobe = r_step_strobe;
    assign o_note_valid  = r_note_valid;
    assign o_note_pitch  = r_note_pitch;
    assign o_overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sequencer_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequencer_player
// Description : Self-checking bench for sequencer_player: cycle model of the
//               playback rules compared every cycle, plus directed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequencer_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] beats = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [23:0] tps = 24'd4;
    logic        note_ready = 1'b0;

    logic        playing;
    logic [3:0]  beat_index;
    logic        step_strobe;
    logic        note_valid;
    logic [2:0]  note_pitch;
    logic        overrun;
    logic        gate;

    int n_tests = 0;
    int n_fail  = 0;

    sequencer_player #(.TICK_W(24)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_beats          (beats),
        .i_start          (start),
        .i_stop           (stop),
        .i_ticks_per_step (tps),
        .o_playing        (playing),
        .o_beat_index     (beat_index),
        .o_step_strobe    (step_strobe),
        .o_note_valid     (note_valid),
        .o_note_pitch     (note_pitch),
        .i_note_ready     (note_ready),
        .o_overrun        (overrun),
        .o_gate           (gate)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_play = 0, m_idx = 0, m_cnt = 0, m_per = 1;
    int m_valid = 0, m_pitch = 0, m_strobe = 0, m_ovr = 0, m_gstep = 0;
    int ni, p;
    bit bd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_play = 0; m_idx = 0; m_cnt = 0; m_per = 1;
            m_valid = 0; m_pitch = 0; m_strobe = 0; m_ovr = 0; m_gstep = 0;
        end else begin
            m_strobe = 0;
            m_ovr    = 0;
            if (m_play != 0 && stop) begin
                m_play = 0; m_idx = 0; m_cnt = 0; m_valid = 0; m_gstep = 0;
            end else if (m_play != 0 || (start && !stop)) begin
                bd = 1'b0;
                ni = 0;
                if (start && !stop) begin
                    bd = 1'b1; ni = 0;
                end else if (m_cnt + 1 >= m_per) begin
                    bd = 1'b1; ni = (m_idx + 1) % 16;
                end
                if (bd) begin
                    m_play   = 1;
                    m_idx    = ni;
                    m_cnt    = 0;
                    m_per    = (tps == 0) ? 1 : int'(tps);
                    m_strobe = 1;
                    p        = int'((beats >> (ni * 3)) & 48'd7);
                    m_gstep  = (p != 0) ? 1 : 0;
                    if (p != 0) begin
                        if (m_valid != 0 && !note_ready) m_ovr = 1;
                        m_valid = 1;
                        m_pitch = p;
                    end else if (m_valid != 0 && note_ready) begin
                        m_valid = 0;
                    end
                end else begin
                    m_cnt = m_cnt + 1;
                    if (m_valid != 0 && note_ready) m_valid = 0;
                end
            end
        end
    end

    function automatic int exp_gate();
`ifdef SEQUENCER_PLAYER_GATE_EN
        return (m_play != 0 && m_gstep != 0 && m_cnt < (m_per - m_per / 4)) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Every-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        logic [13:0] act, expv;
        act  = {playing, beat_index, step_strobe, note_valid, note_pitch, overrun, gate};
        expv = {m_play[0], m_idx[3:0], m_strobe[0], m_valid[0], m_pitch[2:0],
                m_ovr[0], exp_gate() != 0};
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act, expv);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    int gcnt;

    initial begin
        cyc(3);
        chk("rst_playing", int'(playing), 0);
        chk("rst_valid", int'(note_valid), 0);
        rst_n = 1'b1;
        cyc(2);
        chk("idle_playing", int'(playing), 0);

        // Basic playback: 5 at step 0, 3 at step 2, ready high.
        beats = 48'd0;
        beats[2:0] = 3'd5;
        beats[8:6] = 3'd3;
        tps = 24'd4;
        note_ready = 1'b1;
        pulse_start();
        chk("t1_idx0", int'(beat_index), 0);
        chk("t1_strobe0", int'(step_strobe), 1);
        chk("t1_valid0", int'(note_valid), 1);
        chk("t1_pitch0", int'(note_pitch), 5);
        cyc(1);
        chk("t1_xfer", int'(note_valid), 0);
        cyc(3);
        chk("t1_idx1", int'(beat_index), 1);
        chk("t1_rest_valid", int'(note_valid), 0);
        cyc(4);
        chk("t1_idx2", int'(beat_index), 2);
        chk("t1_pitch2", int'(note_pitch), 3);
        cyc(55);
        chk("t1_idx15", int'(beat_index), 15);
        cyc(1);
        chk("t1_wrap_idx", int'(beat_index), 0);
        chk("t1_wrap_pitch", int'(note_pitch), 5);
        do_stop();
        chk("t1_stop_play", int'(playing), 0);

        // Overrun: steps 0 and 1 both pitch 7, ready low.
        beats = 48'd0;
        beats[2:0] = 3'd7;
        beats[5:3] = 3'd7;
        note_ready = 1'b0;
        tps = 24'd2;
        pulse_start();
        chk("t2_ovr0", int'(overrun), 0);
        cyc(2);
        chk("t2_idx1", int'(beat_index), 1);
        chk("t2_ovr1", int'(overrun), 1);
        chk("t2_hold_valid", int'(note_valid), 1);
        chk("t2_hold_pitch", int'(note_pitch), 7);
        cyc(1);
        chk("t2_ovr_pulse", int'(overrun), 0);
        note_ready = 1'b1;
        cyc(1);
        chk("t2_xfer", int'(note_valid), 0);
        note_ready = 1'b0;

        // Start and stop together while playing with a note pending.
        pulse_start();
        chk("t3_pending", int'(note_valid), 1);
        start = 1'b1; stop = 1'b1;
        cyc(1);
        chk("t3_stop_play", int'(playing), 0);
        chk("t3_stop_valid", int'(note_valid), 0);
        chk("t3_stop_idx", int'(beat_index), 0);
        cyc(1);
        start = 1'b0; stop = 1'b0;
        chk("t3_idle_stay", int'(playing), 0);
        cyc(2);

        // Tempo change mid-step, then zero tempo.
        beats = 48'd0;
        note_ready = 1'b1;
        tps = 24'd3;
        pulse_start();
        tps = 24'd10;
        chk("t4_strobe0", int'(step_strobe), 1);
        cyc(3);
        chk("t4_strobe1", int'(step_strobe), 1);
        chk("t4_idx1", int'(beat_index), 1);
        cyc(9);
        chk("t4_nostrobe", int'(step_strobe), 0);
        cyc(1);
        chk("t4_strobe2", int'(step_strobe), 1);
        chk("t4_idx2", int'(beat_index), 2);
        tps = 24'd0;
        cyc(10);
        chk("t4_idx3", int'(beat_index), 3);
        cyc(1);
        chk("t4_fast_idx4", int'(beat_index), 4);
        chk("t4_fast_strobe", int'(step_strobe), 1);
        do_stop();

        // Reset mid-play with a note pending.
        beats = 48'd0;
        beats[2:0] = 3'd7;
        note_ready = 1'b0;
        tps = 24'd4;
        pulse_start();
        cyc(1);
        chk("t5_pre_valid", int'(note_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_play", int'(playing), 0);
        chk("t5_rst_valid", int'(note_valid), 0);
        chk("t5_rst_pitch", int'(note_pitch), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("t5_idle_after", int'(playing), 0);

        // Gate: pitch 4 then a rest, 8-cycle steps.
        beats = 48'd0;
        beats[2:0] = 3'd4;
        note_ready = 1'b1;
        tps = 24'd8;
        pulse_start();
        gcnt = 0;
        for (int i = 0; i < 8; i++) begin
            gcnt += int'(gate);
            cyc(1);
        end
`ifdef SEQUENCER_PLAYER_GATE_EN
        chk("t6_gate_note", gcnt, 6);
`else
        chk("t6_gate_note", gcnt, 0);
`endif
        chk("t6_idx1", int'(beat_index), 1);
        gcnt = 0;
        for (int i = 0; i < 8; i++) begin
            gcnt += int'(gate);
            cyc(1);
        end
        chk("t6_gate_rest", gcnt, 0);
        do_stop();
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
